// File: rtl/reg_bank_master.sv
// Command sequencer for the 8-entry register bank: WRITE/READ/MOVE/INC become bank read and write cycles.
// Latency: WRITE 1 cycle to wr_en, READ response 2 cycles after accept, MOVE/INC write 2 cycles after accept.
// Backpressure: one command in flight (cmd_ready only in IDLE); RSP holds until rsp_ready is sampled high.
module reg_bank_master #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [2:0]            cmd_dst,
    input  logic [2:0]            cmd_src,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  wr_en,
    output logic [2:0]            w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [2:0]            r_addr,
    input  logic [DATA_WIDTH-1:0] bus_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b11;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [1:0]            op_q, op_nxt;
    logic [2:0]            dst_q, dst_nxt;
    logic                  wr_en_nxt;
    logic [2:0]            w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [2:0]            r_addr_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;

    // Accept only while idle and out of reset; no command queueing.
    assign cmd_ready = (state == IDLE) && !reset;

    // State and registered bank/response outputs; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            dst_q     <= 3'd0;
            wr_en     <= 1'b0;
            w_addr    <= 3'd0;
            w_data    <= '0;
            r_addr    <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            dst_q     <= dst_nxt;
            wr_en     <= wr_en_nxt;
            w_addr    <= w_addr_nxt;
            w_data    <= w_data_nxt;
            r_addr    <= r_addr_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    // Next-state and next-output decode; addresses and data hold unless a new cycle loads them.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        dst_nxt       = dst_q;
        wr_en_nxt     = 1'b0;
        w_addr_nxt    = w_addr;
        w_data_nxt    = w_data;
        r_addr_nxt    = r_addr;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nxt  = cmd_op;
                    dst_nxt = cmd_dst;
                    if (cmd_op == OP_WRITE) begin
                        state_nxt  = WR;
                        wr_en_nxt  = 1'b1;
                        w_addr_nxt = cmd_dst;
                        w_data_nxt = cmd_data;
                    end else begin
                        state_nxt  = RD;
                        r_addr_nxt = (cmd_op == OP_INC) ? cmd_dst : cmd_src;
                    end
                end
            end
            RD: begin
                if (op_q == OP_READ) begin
                    state_nxt     = RSP;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = bus_b;
                end else begin
                    state_nxt  = WR;
                    wr_en_nxt  = 1'b1;
                    w_addr_nxt = dst_q;
                    w_data_nxt = (op_q == OP_INC) ? (bus_b + ONE) : bus_b;
                end
            end
            WR: begin
                state_nxt = IDLE;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_bank_master.sv
// Bench for reg_bank_master: bank array driven by the DUT, transaction-level model, per-cycle compare.
// Directed scenarios pin literal values; a randomized phase with sporadic resets follows.
// Inputs are driven on the falling edge; outputs are compared 1 time unit after it.
module tb_reg_bank_master;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPR = 2'b01;
    localparam logic [1:0] OPM = 2'b10;
    localparam logic [1:0] OPI = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_dst = 3'd0;
    logic [2:0] cmd_src = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       wr_en;
    logic [2:0] w_addr;
    logic [3:0] w_data;
    logic [2:0] r_addr;
    logic [3:0] bus_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_master #(.DATA_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .r_addr(r_addr),
        .bus_b(bus_b)
    );

    // The register bank itself: registered write, combinational read of r_addr.
    logic [3:0] bank [8] = '{default: 4'd0};
    assign bus_b = bank[r_addr];
    always @(posedge clk) begin
        if (wr_en === 1'b1) bank[w_addr] <= w_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: architectural register file plus the phase of the single command in flight.
    logic [3:0] m_regs [8] = '{default: 4'd0};
    bit         m_started = 0;
    bit         m_busy = 0;
    logic [1:0] m_op = 2'b00;
    logic [2:0] m_dst = 3'd0;
    logic [3:0] m_val = 4'd0;
    int         m_ph = 0;
    logic [2:0] m_waddr = 3'd0;
    logic [2:0] m_raddr = 3'd0;
    logic [3:0] m_wdata = 4'd0;
    logic [3:0] m_rspdata = 4'd0;
    int         cyc = 0;
    int         m_acc_cnt = 0;
    int         m_acc_cyc = 0;

    always @(posedge clk) begin
        bit commit;
        cyc++;
        commit = m_busy && ((m_op == OPW && m_ph == 1) ||
                            ((m_op == OPM || m_op == OPI) && m_ph == 2));
        if (commit) m_regs[m_dst] = m_val;
        if (reset) begin
            m_started = 1;
            m_busy    = 0;
            m_waddr   = 3'd0;
            m_raddr   = 3'd0;
            m_wdata   = 4'd0;
            m_rspdata = 4'd0;
        end else if (m_busy) begin
            if (commit) begin
                m_busy = 0;
            end else if (m_op == OPR && m_ph >= 2) begin
                if (rsp_ready) m_busy = 0;
            end else begin
                if (m_op == OPR) begin
                    m_rspdata = m_val;
                end else begin
                    m_waddr = m_dst;
                    m_wdata = m_val;
                end
                m_ph++;
            end
        end else if (cmd_valid) begin
            m_busy = 1;
            m_ph   = 1;
            m_op   = cmd_op;
            m_dst  = cmd_dst;
            m_acc_cnt++;
            m_acc_cyc = cyc;
            case (cmd_op)
                OPW: begin
                    m_val   = cmd_data;
                    m_waddr = cmd_dst;
                    m_wdata = cmd_data;
                end
                OPR, OPM: begin
                    m_val   = m_regs[cmd_src];
                    m_raddr = cmd_src;
                end
                default: begin
                    m_val   = m_regs[cmd_dst] + 4'd1;
                    m_raddr = cmd_dst;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of every DUT output and the bank contents against the model.
    always @(negedge clk) begin
        #1;
        if (m_started) begin
            bit bank_ok;
            chk("cmd_ready", cmd_ready, !m_busy && !reset);
            chk("wr_en", wr_en, m_busy && ((m_op == OPW && m_ph == 1) ||
                                           ((m_op == OPM || m_op == OPI) && m_ph == 2)));
            chk("w_addr", w_addr, m_waddr);
            chk("w_data", w_data, m_wdata);
            chk("r_addr", r_addr, m_raddr);
            chk("rsp_valid", rsp_valid, m_busy && m_op == OPR && m_ph >= 2);
            chk("rsp_data", rsp_data, m_rspdata);
            bank_ok = 1;
            for (int i = 0; i < 8; i++) if (bank[i] !== m_regs[i]) bank_ok = 0;
            chk("bank_contents", bank_ok, 1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command and return on the falling edge right after it is accepted.
    task automatic send(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [3:0] data, input bit hold);
        int t;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_data  = data;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (cmd_ready !== 1'b1) chk("send_timeout", 0, 1);
        tick();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [3:0] d, output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        if (rsp_valid !== 1'b1) chk("rsp_timeout", 0, 1);
        d = rsp_data;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [3:0] d;
        int lat, n, cnt, acc, prev;
        logic [2:0] hd [4] = '{3'd0, 3'd4, 3'd0, 3'd4};
        logic [3:0] hv [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_r_addr", r_addr, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_rsp_data", rsp_data, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        // WRITE r2=A: single wr_en pulse; READ r2 response two cycles after accept
        rsp_ready = 1'b1;
        send(OPW, 3'd2, 3'd0, 4'hA, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr_en === 1'b1) cnt++;
            tick();
        end
        chk("write_pulse_count", cnt, 1);
        send(OPR, 3'd0, 3'd2, 4'h0, 0);
        wait_rsp(d, lat);
        chk("read_latency", lat, 1);
        chk("read_r2", d, 4'hA);

        // INC wrap: r3=F -> 0, three cycles from accept to IDLE
        send(OPW, 3'd3, 3'd0, 4'hF, 0);
        wait_idle(n);
        chk("write_accept_to_idle", n + 1, 2);
        send(OPI, 3'd3, 3'd0, 4'h0, 0);
        wait_idle(n);
        chk("inc_accept_to_idle", n + 1, 3);
        send(OPR, 3'd0, 3'd3, 4'h0, 0);
        wait_rsp(d, lat);
        chk("inc_wrap", d, 4'h0);
        chk("model_r3_wrap", m_regs[3], 4'h0);

        // MOVE r1 -> r6, source unchanged
        send(OPW, 3'd1, 3'd0, 4'h5, 0);
        send(OPM, 3'd6, 3'd1, 4'h0, 0);
        send(OPR, 3'd0, 3'd6, 4'h0, 0);
        wait_rsp(d, lat);
        chk("move_r6", d, 4'h5);
        send(OPR, 3'd0, 3'd1, 4'h0, 0);
        wait_rsp(d, lat);
        chk("move_src_r1", d, 4'h5);

        // Response stall: four cycles with rsp_ready low and a command waiting
        tick();
        rsp_ready = 1'b0;
        send(OPR, 3'd0, 3'd6, 4'h0, 0);
        cmd_valid = 1'b1;
        cmd_op    = OPW;
        cmd_dst   = 3'd7;
        cmd_data  = 4'hC;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", rsp_data, 4'h5);
            chk("stall_cmd_ready", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("ready_after_handshake", cmd_ready, 1);
        acc = m_acc_cnt;
        tick();
        chk("accept_after_handshake", m_acc_cnt, acc + 1);
        chk("held_write_wr_en", wr_en, 1);
        cmd_valid = 1'b0;
        tick();

        // Held cmd_valid with alternating WRITEs: one accept every 2 cycles
        acc  = m_acc_cnt;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(OPW, hd[i], 3'd0, hv[i], 1);
            if (i > 0) chk("held_write_gap", m_acc_cyc - prev, 2);
            prev = m_acc_cyc;
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("held_write_count", m_acc_cnt - acc, 4);
        chk("held_r0", bank[0], 4'h3);
        chk("held_r4", bank[4], 4'h4);

        // Reset during RD of MOVE r7 -> r6: no write, outputs cleared, r6 kept
        send(OPM, 3'd6, 3'd7, 4'h0, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_w_addr", w_addr, 0);
        chk("mid_rst_w_data", w_data, 0);
        chk("mid_rst_r_addr", r_addr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_en === 1'b1) cnt++;
        end
        chk("mid_rst_no_write", cnt, 0);
        chk("mid_rst_r6_kept", bank[6], 4'h5);
        chk("mid_rst_r7", bank[7], 4'hC);

        // Randomized traffic with sporadic resets, checked by the per-cycle compare
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_dst   = 3'($urandom_range(0, 7));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_data  = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) tick();
        chk("random_accepts_seen", (m_acc_cnt > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
